// File: rtl/pc_fetch_unit.sv
// Program counter plus the IR, MDR and ALUOut holding registers of the multicycle MIPS datapath.
// Drives the shared memory address and the decoded instruction fields.
module pc_fetch_unit #(
    parameter int               WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = 32'h0040_0000,
    parameter int               CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             PC_W,
    input  logic             Branch,
    input  logic             PC_Src,
    input  logic             PCJump,
    input  logic             IR_W,
    input  logic             InsDat,
    input  logic             zero,
    input  logic [WIDTH-1:0] alu_result,
    input  logic [WIDTH-1:0] mem_rdata,
    output logic [WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] ir,
    output logic [5:0]       Op,
    output logic [5:0]       Funct,
    output logic [4:0]       rs,
    output logic [4:0]       rt,
    output logic [4:0]       rd,
    output logic [15:0]      imm,
    output logic [WIDTH-1:0] mdr,
    output logic [WIDTH-1:0] alu_out,
    output logic [CNT_W-1:0] instr_count
);

    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] ir_q, ir_d;
    logic [WIDTH-1:0] mdr_q, alu_out_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             pc_en;
    logic [WIDTH-1:0] jump_target;
    logic [WIDTH-1:0] src_sel;

    // Jump target reuses the already-incremented pc, so it stays inside the current 256 MB segment.
    assign jump_target = {pc_q[WIDTH-1:WIDTH-4], ir_q[25:0], 2'b00};
    assign src_sel     = PC_Src ? alu_out_q : alu_result;
    assign pc_en       = PC_W | (Branch & zero);

    always_comb begin
        pc_d  = pc_q;
        ir_d  = ir_q;
        cnt_d = cnt_q;
        if (pc_en) begin
            pc_d = PCJump ? src_sel : jump_target;
        end
        if (IR_W) begin
            ir_d  = mem_rdata;
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            pc_q      <= RESET_PC;
            ir_q      <= '0;
            mdr_q     <= '0;
            alu_out_q <= '0;
            cnt_q     <= '0;
        end else begin
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            mdr_q     <= mem_rdata;
            alu_out_q <= alu_result;
            cnt_q     <= cnt_d;
        end
    end

    assign mem_addr    = InsDat ? alu_out_q : pc_q;
    assign pc          = pc_q;
    assign ir          = ir_q;
    assign Op          = ir_q[31:26];
    assign Funct       = ir_q[5:0];
    assign rs          = ir_q[25:21];
    assign rt          = ir_q[20:16];
    assign rd          = ir_q[15:11];
    assign imm         = ir_q[15:0];
    assign mdr         = mdr_q;
    assign alu_out     = alu_out_q;
    assign instr_count = cnt_q;

endmodule
